// File: rtl/mux_scan_serializer.sv
// Parallel-to-serial front end for an external 8:1 mux: holds the word on
// the mux inputs, walks the select and registers each sampled bit out.
module mux_scan_serializer #(
   parameter  int SEL_W     = 3,
   parameter  bit MSB_FIRST = 1'b0,
   localparam int N         = 1 << SEL_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   output logic [N-1:0]     word_o,
   output logic [SEL_W-1:0] sel_o,
   input  logic             mux_bit_i,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_data,
   output logic             ser_last,
   output logic             busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [SEL_W-1:0] SEL_MAX   = {SEL_W{1'b1}};
   localparam logic [SEL_W-1:0] SEL_ONE   = {{(SEL_W-1){1'b0}}, 1'b1};
   localparam logic [SEL_W-1:0] FIRST_SEL = MSB_FIRST ? SEL_MAX : '0;
   localparam logic [SEL_W-1:0] FINAL_SEL = MSB_FIRST ? '0 : SEL_MAX;

   state_t           state_q, state_d;
   logic [N-1:0]     word_q, word_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             valid_q, valid_d;
   logic             data_q, data_d;
   logic             last_q, last_d;
   logic             cap;
   logic             at_final;

   // A capture is allowed whenever the output slot is empty or draining.
   assign cap      = (state_q == SHIFT) && (!valid_q || ser_ready);
   assign at_final = (sel_q == FINAL_SEL);

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = SHIFT;
               word_d  = in_data;
               sel_d   = FIRST_SEL;
            end
         end
         SHIFT: begin
            if (cap) begin
               if (at_final) begin
                  state_d = IDLE;
               end else if (MSB_FIRST) begin
                  sel_d = sel_q - SEL_ONE;
               end else begin
                  sel_d = sel_q + SEL_ONE;
               end
            end
         end
      endcase

      if (cap) begin
         data_d  = mux_bit_i;
         valid_d = 1'b1;
         last_d  = at_final;
      end else if (valid_q && ser_ready) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         word_q  <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == SHIFT);
   assign word_o    = word_q;
   assign sel_o     = sel_q;
   assign ser_valid = valid_q;
   assign ser_data  = data_q;
   assign ser_last  = last_q;

endmodule
